// File: rtl/arb_mux.sv
// arb_mux -- N-channel input arbiter feeding a single registered output slot.
//
// Each cycle one channel is chosen, either by the external sel (MODE=0) or by
// a round-robin search starting after the last granted channel (MODE=1). The
// chosen channel's word is captured into a one-deep output register. A new
// word may enter in the same cycle the old one drains, so the block sustains
// one word per clock.
//
// Handshake: a word moves on an edge where valid and ready are both 1. The
// producer holds valid/data stable until it sees ready. The consumer of
// out_valid/out_data is free to drop out_ready at any time.
//
// Ports:
//   clk         single clock, all state on rising edge
//   reset       asynchronous, active-high reset
//   in_valid    per-channel data valid                  [CHANNELS]
//   in_data     channel i at bits [i*WIDTH +: WIDTH]    [CHANNELS*WIDTH]
//   in_ready    per-channel accept, combinational       [CHANNELS]
//   sel         channel select, MODE=0 only             [SEL_W]
//   out_valid   output register holds a word
//   out_data    registered word                         [WIDTH]
//   out_chan    source channel of out_data              [SEL_W]
//   out_ready   downstream accept
//   xfer_count  accepted input transfers, wraps         [COUNT_W]
module arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int COUNT_W  = 16,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic [COUNT_W-1:0]        xfer_count
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_chan;
  logic             rr_found;
  logic             sel_ok;
  logic [SEL_W-1:0] chosen;
  logic             chosen_ok;
  logic [WIDTH-1:0] chosen_data;
  logic             free;
  logic             xfer;

  // The slot can take a word if it is empty or is being emptied this cycle.
  assign free = ~out_valid | out_ready;

  // sel is wider than needed when CHANNELS is not a power of two.
  assign sel_ok = (int'(sel) < CHANNELS);

  // Round-robin search order is ptr+1 .. CHANNELS-1, then 0 .. ptr.
  // Scanning in reverse priority order and letting later hits overwrite
  // earlier ones leaves the highest-priority requester as the winner: the
  // first pass settles the wrapped group (0..ptr), the second pass lets any
  // requester above ptr override it.
  always_comb begin
    rr_found = 1'b0;
    rr_chan  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && (i <= int'(ptr))) begin
        rr_found = 1'b1;
        rr_chan  = SEL_W'(i);
      end
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && (i > int'(ptr))) begin
        rr_found = 1'b1;
        rr_chan  = SEL_W'(i);
      end
    end
  end

  assign chosen    = (MODE == 0) ? sel : rr_chan;
  assign chosen_ok = (MODE == 0) ? sel_ok : rr_found;

  always_comb begin
    chosen_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == chosen) begin
        chosen_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // In MODE=0 ready is offered to the selected channel whether or not it is
  // requesting, so ready never combinationally depends on in_valid there.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = ~reset & free & chosen_ok & (SEL_W'(i) == chosen);
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      xfer_count <= '0;
      // Start just below channel 0 so channel 0 is searched first.
      ptr        <= SEL_W'(CHANNELS - 1);
    end else begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= chosen_data;
        out_chan   <= chosen;
        xfer_count <= xfer_count + COUNT_W'(1);
        if (MODE == 1) begin
          ptr <= chosen;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux -- two arb_mux instances checked against a behavioural model.
//   dut_a: MODE=0, CHANNELS=5 (so sel can point past the last channel),
//          COUNT_W=4 (counter wrap reachable quickly)
//   dut_b: MODE=1, CHANNELS=4, COUNT_W=16
// A negedge process compares every output of both instances with the model
// each cycle; the main process drives directed scenarios with literal
// expectations, then randomized traffic with occasional reset pulses.
module tb_arb_mux;

  localparam int W = 32;

  logic clk;
  logic reset;

  logic [4:0]   a_in_valid, a_in_ready;
  logic [159:0] a_in_data;
  logic [2:0]   a_sel, a_out_chan;
  logic         a_out_valid, a_out_ready;
  logic [31:0]  a_out_data;
  logic [3:0]   a_count;

  logic [3:0]   b_in_valid, b_in_ready;
  logic [127:0] b_in_data;
  logic [1:0]   b_sel, b_out_chan;
  logic         b_out_valid, b_out_ready;
  logic [31:0]  b_out_data;
  logic [15:0]  b_count;

  int n_tests = 0;
  int n_fail  = 0;

  arb_mux #(.WIDTH(W), .CHANNELS(5), .MODE(0), .COUNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .sel(a_sel), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_chan(a_out_chan), .out_ready(a_out_ready),
    .xfer_count(a_count)
  );

  arb_mux #(.WIDTH(W), .CHANNELS(4), .MODE(1), .COUNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .sel(b_sel), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_ready(b_out_ready),
    .xfer_count(b_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int          m_mode[2] = '{0, 1};
  int          m_ch[2]   = '{5, 4};
  int          m_cw[2]   = '{4, 16};
  bit          m_valid[2];
  logic [31:0] m_data[2];
  int          m_chan[2];
  int          m_count[2];
  int          m_ptr[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the spec's rules pick, or -1 when none.
  function automatic int choose(int d, logic [15:0] v, int s);
    if (m_mode[d] == 0) return (s < m_ch[d]) ? s : -1;
    for (int k = 1; k <= m_ch[d]; k++) begin
      int i;
      i = (m_ptr[d] + k) % m_ch[d];
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_valid[d] = 1'b0;
    m_data[d]  = '0;
    m_chan[d]  = 0;
    m_count[d] = 0;
    m_ptr[d]   = m_ch[d] - 1;
  endtask

  // Compare one instance against the model, then advance the model by the
  // edge that follows (inputs are stable from here to that edge).
  task automatic step(input int d, input logic rst, input logic [15:0] v, input int s,
                      input logic [511:0] dat, input logic ordy, input logic [15:0] rdy,
                      input logic ov, input logic [31:0] od, input int oc, input int cnt);
    string p;
    int c;
    bit fr, xf;
    logic [15:0] exp_rdy;
    p = (d == 0) ? "a" : "b";
    if (rst) model_reset(d);
    check({p, ".out_valid"}, 64'(ov), 64'(m_valid[d]));
    check({p, ".out_data"}, 64'(od), 64'(m_data[d]));
    check({p, ".out_chan"}, 64'(oc), 64'(m_chan[d]));
    check({p, ".xfer_count"}, 64'(cnt), 64'(m_count[d]));
    fr = !m_valid[d] || ordy;
    c = choose(d, v, s);
    exp_rdy = '0;
    if (!rst && fr && c >= 0) exp_rdy[c] = 1'b1;
    check({p, ".in_ready"}, 64'(rdy), 64'(exp_rdy));
    if (rst) return;
    xf = (c >= 0) && fr && v[c];
    if (xf) begin
      m_valid[d] = 1'b1;
      m_data[d]  = dat[c*32 +: 32];
      m_chan[d]  = c;
      m_count[d] = (m_count[d] + 1) % (1 << m_cw[d]);
      if (m_mode[d] == 1) m_ptr[d] = c;
    end else if (ordy) begin
      m_valid[d] = 1'b0;
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      step(0, reset, {11'b0, a_in_valid}, int'(a_sel), {352'b0, a_in_data}, a_out_ready,
           {11'b0, a_in_ready}, a_out_valid, a_out_data, int'(a_out_chan), int'(a_count));
      step(1, reset, {12'b0, b_in_valid}, int'(b_sel), {384'b0, b_in_data}, b_out_ready,
           {12'b0, b_in_ready}, b_out_valid, b_out_data, int'(b_out_chan), int'(b_count));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 5; i++) a_in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = $urandom;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] b_words[4];
    reset = 1'b1;
    a_in_valid = '0; a_in_data = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_valid = '0; b_in_data = '0; b_sel = '0; b_out_ready = 1'b1;
    rand_data();
    repeat (3) tick();
    check("reset.a_in_ready", 64'(a_in_ready), 64'd0);
    check("reset.b_out_valid", 64'(b_out_valid), 64'd0);

    // Round-robin with all channels requesting: 0,1,2,3,0,1,2,3.
    reset = 1'b0;
    b_in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) b_words[i] = b_in_data[i*32 +: 32];
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr.out_chan", 64'(b_out_chan), 64'(k % 4));
      check("rr.out_valid", 64'(b_out_valid), 64'd1);
      check("rr.out_data", 64'(b_out_data), 64'(b_words[k % 4]));
      check("rr.count", 64'(b_count), 64'(k + 1));
    end
    b_in_valid = '0;

    // Explicit select, single transfer.
    a_sel = 3'd2;
    a_in_valid = 5'b00100;
    a_in_data[64 +: 32] = 32'hDEADBEEF;
    tick();
    check("sel2.out_valid", 64'(a_out_valid), 64'd1);
    check("sel2.out_data", 64'(a_out_data), 64'hDEADBEEF);
    check("sel2.out_chan", 64'(a_out_chan), 64'd2);
    check("sel2.count", 64'(a_count), 64'd1);
    a_in_valid = '0;

    // Round-robin stall: ptr=3, so 4'b1010 grants 1, then 3 after the stall.
    b_in_valid = 4'b1010;
    tick();
    check("stall.first_chan", 64'(b_out_chan), 64'd1);
    b_out_ready = 1'b0;
    #1 check("stall.in_ready", 64'(b_in_ready), 64'd0);
    repeat (3) tick();
    check("stall.hold_chan", 64'(b_out_chan), 64'd1);
    check("stall.hold_valid", 64'(b_out_valid), 64'd1);
    b_out_ready = 1'b1;
    #1 check("stall.release_ready", 64'(b_in_ready), 64'b1000);
    tick();
    check("stall.next_chan", 64'(b_out_chan), 64'd3);
    b_in_valid = '0;

    // sel past the last channel: never ready, never transfers.
    a_sel = 3'd5;
    a_in_valid = 5'b11111;
    repeat (4) begin
      tick();
      check("oob.in_ready", 64'(a_in_ready), 64'd0);
      check("oob.out_valid", 64'(a_out_valid), 64'd0);
      check("oob.count", 64'(a_count), 64'd1);
    end
    a_in_valid = '0;

    // 17 back-to-back transfers into a 4-bit counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_sel = 3'd1;
    a_in_valid = 5'b00010;
    repeat (17) tick();
    check("wrap.count", 64'(a_count), 64'd1);
    a_in_valid = '0;

    // Reset while a word is held under back-pressure.
    b_in_valid = 4'b0100;
    b_out_ready = 1'b0;
    tick();
    b_in_valid = '0;
    tick();
    check("rst_stall.held", 64'(b_out_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_stall.out_valid", 64'(b_out_valid), 64'd0);
    check("rst_stall.out_data", 64'(b_out_data), 64'd0);
    check("rst_stall.count", 64'(b_count), 64'd0);
    check("rst_stall.in_ready", 64'(b_in_ready), 64'd0);
    tick();
    reset = 1'b0;
    b_in_valid = 4'b1111;
    b_out_ready = 1'b1;
    tick();
    check("rst_stall.grant0", 64'(b_out_chan), 64'd0);
    check("rst_stall.valid", 64'(b_out_valid), 64'd1);

    // Randomized traffic; the negedge process checks every cycle.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_in_valid = 5'($urandom);
      b_in_valid = 4'($urandom);
      a_sel = 3'($urandom_range(0, 7));
      b_sel = 2'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
    end
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
